// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory controller.
//   - funct3 load encodings, FSM state encoding, latched request payload
//   - size_bytes(): access size in bytes from funct3[1:0]
package data_memory_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned MASK_WIDTH = 8;

  localparam logic [2:0] F3_LB         = 3'b000;
  localparam logic [2:0] F3_LH         = 3'b001;
  localparam logic [2:0] F3_LW         = 3'b010;
  localparam logic [2:0] F3_LD         = 3'b011;
  localparam logic [2:0] F3_LBU        = 3'b100;
  localparam logic [2:0] F3_LHU        = 3'b101;
  localparam logic [2:0] F3_LWU        = 3'b110;
  localparam logic [2:0] F3_LOAD_ILLEG = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Request fields held for the whole access
  typedef struct packed {
    logic                  write;
    logic [2:0]            funct3;
    logic [2:0]            offset;
    logic [DATA_WIDTH-1:0] store_data;
  } req_t;

  // 1/2/4/8 bytes
  function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
    return 4'(4'd1 << size_code);
  endfunction

endpackage

// File: rtl/data_memory_align.sv
// Combinational lane alignment for the data memory controller.
//   funct3, offset      : access size/signedness and byte offset in the word
//   store_data          : right-aligned store data
//   lo, hi              : captured RAM words (hi = 0 for non-crossing loads)
//   store_mask/value    : 16-bit mask and 128-bit data spanning {w1, w0}
//   load_value          : extracted and extended load result
module data_memory_align
  import data_memory_pkg::*;
(
  input  logic [2:0]              funct3,
  input  logic [2:0]              offset,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   lo,
  input  logic [DATA_WIDTH-1:0]   hi,
  output logic [2*MASK_WIDTH-1:0] store_mask,
  output logic [2*DATA_WIDTH-1:0] store_value,
  output logic [DATA_WIDTH-1:0]   load_value
);

  logic [3:0]            size;
  logic [5:0]            shamt;
  logic [15:0]           base_mask;
  logic [DATA_WIDTH-1:0] shifted;

  // Store placement and load extraction over the two-word window
  always_comb begin
    load_value  = '0;
    size        = size_bytes(funct3[1:0]);
    shamt       = {offset, 3'b000};
    base_mask   = 16'((16'd1 << size) - 16'd1);
    store_mask  = 16'(base_mask << offset);
    store_value = 128'(128'(store_data) << shamt);
    shifted     = 64'({hi, lo} >> shamt);
    unique case (funct3[1:0])
      2'd0: load_value = funct3[2] ? 64'(shifted[7:0])  : 64'($signed(shifted[7:0]));
      2'd1: load_value = funct3[2] ? 64'(shifted[15:0]) : 64'($signed(shifted[15:0]));
      2'd2: load_value = funct3[2] ? 64'(shifted[31:0]) : 64'($signed(shifted[31:0]));
      2'd3: load_value = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// RV64 load/store initiator for a 64-bit byte-masked data RAM.
//   clk_in, rst_n_in        : clock, synchronous active-low reset
//   req_*                   : valid/ready request (write, funct3, byte address, store data)
//   resp_*                  : one-cycle completion pulse, load data, illegal-funct3 error
//   ram_*                   : word address, lane data, byte mask, write/read strobes, read data
// Accesses crossing a 64-bit word boundary are split into two RAM transactions.
module data_memory_controller
  import data_memory_pkg::*;
#(
  parameter int unsigned WORD_ADDR_WIDTH = 10
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [2:0]                 req_funct3_in,
  input  logic [WORD_ADDR_WIDTH+2:0] req_address_in,
  input  logic [DATA_WIDTH-1:0]      req_store_data_in,
  output logic                       resp_valid_out,
  output logic [DATA_WIDTH-1:0]      resp_load_data_out,
  output logic                       resp_error_out,
  output logic [WORD_ADDR_WIDTH-1:0] ram_address_out,
  output logic [DATA_WIDTH-1:0]      ram_value_out,
  output logic [MASK_WIDTH-1:0]      ram_mask_out,
  output logic                       ram_write_signal_out,
  output logic                       ram_read_signal_out,
  input  logic [DATA_WIDTH-1:0]      ram_read_value_in
);

  localparam int unsigned BYTE_ADDR_WIDTH = WORD_ADDR_WIDTH + 3;

  state_t                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [WORD_ADDR_WIDTH-1:0] w0_q, w0_d, w1_d;
  logic                       cross_q, cross_d;
  logic                       err_q, err_d;
  logic [DATA_WIDTH-1:0]      lo_q, lo_d, hi_q, hi_d;
  logic                       illegal;

  logic                       ready_q, ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]      resp_data_q, resp_data_d;
  logic                       resp_err_q, resp_err_d;
  logic [WORD_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]      ram_value_q, ram_value_d;
  logic [MASK_WIDTH-1:0]      ram_mask_q, ram_mask_d;
  logic                       ram_wr_q, ram_wr_d;
  logic                       ram_rd_q, ram_rd_d;

  logic [2*MASK_WIDTH-1:0]    store_mask;
  logic [2*DATA_WIDTH-1:0]    store_value;
  logic [DATA_WIDTH-1:0]      load_value;

  // Aligner works on the request that the next cycle will act on
  data_memory_align u_align (
    .funct3      (req_d.funct3),
    .offset      (req_d.offset),
    .store_data  (req_d.store_data),
    .lo          (lo_d),
    .hi          (hi_d),
    .store_mask  (store_mask),
    .store_value (store_value),
    .load_value  (load_value)
  );

  assign illegal = req_write_in ? req_funct3_in[2] : (req_funct3_in == F3_LOAD_ILLEG);

  // Next state, request latch and read-data capture
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    w0_d    = w0_q;
    cross_d = cross_q;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          req_d   = '{write:      req_write_in,
                      funct3:     req_funct3_in,
                      offset:     req_address_in[2:0],
                      store_data: req_store_data_in};
          w0_d    = req_address_in[BYTE_ADDR_WIDTH-1:3];
          cross_d = (4'(req_address_in[2:0]) + size_bytes(req_funct3_in[1:0])) > 4'd8;
          err_d   = illegal;
          lo_d    = '0;
          hi_d    = '0;
          state_d = illegal ? DONE : ACC0;
        end
      end
      ACC0: begin
        if (!req_q.write) lo_d = ram_read_value_in;
        state_d = cross_q ? ACC1 : DONE;
      end
      ACC1: begin
        if (!req_q.write) hi_d = ram_read_value_in;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign w1_d = WORD_ADDR_WIDTH'(w0_d + WORD_ADDR_WIDTH'(1));

  // Registered outputs decoded from the state being entered
  always_comb begin
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    resp_err_d   = (state_d == DONE) && err_d;
    resp_data_d  = '0;
    ram_addr_d   = '0;
    ram_value_d  = '0;
    ram_mask_d   = '0;
    ram_wr_d     = 1'b0;
    ram_rd_d     = 1'b0;
    if (state_d == DONE && !err_d && !req_d.write) resp_data_d = load_value;
    if (state_d == ACC0) begin
      ram_addr_d = w0_d;
      ram_wr_d   = req_d.write;
      ram_rd_d   = !req_d.write;
      if (req_d.write) begin
        ram_mask_d  = store_mask[MASK_WIDTH-1:0];
        ram_value_d = store_value[DATA_WIDTH-1:0];
      end
    end else if (state_d == ACC1) begin
      ram_addr_d = w1_d;
      ram_wr_d   = req_d.write;
      ram_rd_d   = !req_d.write;
      if (req_d.write) begin
        ram_mask_d  = store_mask[2*MASK_WIDTH-1:MASK_WIDTH];
        ram_value_d = store_value[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      req_q        <= '0;
      w0_q         <= '0;
      cross_q      <= 1'b0;
      err_q        <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_value_q  <= '0;
      ram_mask_q   <= '0;
      ram_wr_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      w0_q         <= w0_d;
      cross_q      <= cross_d;
      err_q        <= err_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      ram_addr_q   <= ram_addr_d;
      ram_value_q  <= ram_value_d;
      ram_mask_q   <= ram_mask_d;
      ram_wr_q     <= ram_wr_d;
      ram_rd_q     <= ram_rd_d;
    end
  end

  assign req_ready_out      = ready_q;
  assign resp_valid_out     = resp_valid_q;
  assign resp_load_data_out = resp_data_q;
  assign resp_error_out     = resp_err_q;
  assign ram_address_out    = ram_addr_q;
  assign ram_value_out      = ram_value_q;
  assign ram_mask_out       = ram_mask_q;
  // Reset drops the strobes immediately so an aborted access cannot commit at the reset edge
  assign ram_write_signal_out = ram_wr_q & rst_n_in;
  assign ram_read_signal_out  = ram_rd_q & rst_n_in;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed self-checking bench for data_memory_controller with a behavioural
// 1024 x 64 byte-masked RAM (write on posedge, read sampled on negedge).
module tb_data_memory_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [12:0] req_address;
  logic [63:0] req_store_data;
  logic        resp_valid;
  logic [63:0] resp_load_data;
  logic        resp_error;
  logic [9:0]  ram_address;
  logic [63:0] ram_value;
  logic [7:0]  ram_mask;
  logic        ram_write;
  logic        ram_read;
  logic [63:0] ram_rdata;

  logic [63:0] mem [1024];
  logic        clr;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [9:0]  wlog_addr [4];
  logic [7:0]  wlog_mask [4];
  logic [63:0] wlog_val  [4];
  logic [9:0]  rlog_addr [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_controller #(.WORD_ADDR_WIDTH(10)) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .req_valid_in         (req_valid),
    .req_ready_out        (req_ready),
    .req_write_in         (req_write),
    .req_funct3_in        (req_funct3),
    .req_address_in       (req_address),
    .req_store_data_in    (req_store_data),
    .resp_valid_out       (resp_valid),
    .resp_load_data_out   (resp_load_data),
    .resp_error_out       (resp_error),
    .ram_address_out      (ram_address),
    .ram_value_out        (ram_value),
    .ram_mask_out         (ram_mask),
    .ram_write_signal_out (ram_write),
    .ram_read_signal_out  (ram_read),
    .ram_read_value_in    (ram_rdata)
  );

  // RAM write port and write log
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (ram_write) begin
      for (int b = 0; b < 8; b++)
        if (ram_mask[b]) mem[ram_address][8*b +: 8] <= ram_value[8*b +: 8];
      wlog_addr[2'(wr_cnt)] <= ram_address;
      wlog_mask[2'(wr_cnt)] <= ram_mask;
      wlog_val[2'(wr_cnt)]  <= ram_value;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // RAM read port and read log
  always @(negedge clk) begin
    if (ram_read) begin
      ram_rdata             <= mem[ram_address];
      rlog_addr[2'(rd_cnt)] <= ram_address;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request; latency counted in cycles after the accept edge
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [12:0] addr, input logic [63:0] sd,
                        input int exp_lat, input logic exp_err, input logic [63:0] exp_data,
                        input int exp_wr, input int exp_rd,
                        output int wbase, output int rbase);
    int          lat;
    logic        got_err;
    logic [63:0] got_data;
    lat      = 0;
    got_err  = 1'b0;
    got_data = '0;
    @(negedge clk);
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid      = 1'b1;
    req_write      = wr;
    req_funct3     = f3;
    req_address    = addr;
    req_store_data = sd;
    @(posedge clk);
    #1;
    wbase          = wr_cnt;
    rbase          = rd_cnt;
    req_valid      = 1'b0;
    req_write      = ~wr;
    req_funct3     = 3'b011;
    req_address    = 13'h1FF8;
    req_store_data = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat      = k;
        got_err  = resp_error;
        got_data = resp_load_data;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " error"}, 64'(got_err), 64'(exp_err));
    check({tag, " data"}, got_data, exp_data);
    check({tag, " writes"}, 64'(wr_cnt - wbase), 64'(exp_wr));
    check({tag, " reads"}, 64'(rd_cnt - rbase), 64'(exp_rd));
    if (lat != 0) begin
      @(negedge clk);
      check({tag, " pulse width"}, 64'(resp_valid), 64'd0);
      check({tag, " ready back"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb;
    rst_n          = 1'b0;
    clr            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_funct3     = 3'b000;
    req_address    = '0;
    req_store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_data", resp_load_data, 64'd0);
    check("rst resp_error", 64'(resp_error), 64'd0);
    check("rst ram_addr", 64'(ram_address), 64'd0);
    check("rst ram_value", ram_value, 64'd0);
    check("rst ram_mask", 64'(ram_mask), 64'd0);
    check("rst strobes", 64'({ram_write, ram_read}), 64'd0);
    rst_n = 1'b1;
    clr   = 1'b0;

    do_req("sd", 1'b1, 3'b011, 13'h0010, 64'h1122_3344_5566_7788, 2, 1'b0, 64'd0, 1, 0, wb, rb);
    check("sd addr", 64'(wlog_addr[2'(wb)]), 64'd2);
    check("sd mask", 64'(wlog_mask[2'(wb)]), 64'hFF);
    check("sd value", wlog_val[2'(wb)], 64'h1122_3344_5566_7788);
    do_req("ld", 1'b0, 3'b011, 13'h0010, 64'd0, 2, 1'b0, 64'h1122_3344_5566_7788, 0, 1, wb, rb);
    check("ld addr", 64'(rlog_addr[2'(rb)]), 64'd2);

    do_req("sb", 1'b1, 3'b000, 13'h0023, 64'h80, 2, 1'b0, 64'd0, 1, 0, wb, rb);
    check("sb addr", 64'(wlog_addr[2'(wb)]), 64'd4);
    check("sb mask", 64'(wlog_mask[2'(wb)]), 64'h08);
    check("sb value", wlog_val[2'(wb)], 64'h0000_0000_8000_0000);
    do_req("lb", 1'b0, 3'b000, 13'h0023, 64'd0, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, wb, rb);
    do_req("lbu", 1'b0, 3'b100, 13'h0023, 64'd0, 2, 1'b0, 64'h0000_0000_0000_0080, 0, 1, wb, rb);

    do_req("sw cross", 1'b1, 3'b010, 13'h0006, 64'hDEAD_BEEF, 3, 1'b0, 64'd0, 2, 0, wb, rb);
    check("sw w0 addr", 64'(wlog_addr[2'(wb)]), 64'd0);
    check("sw w0 mask", 64'(wlog_mask[2'(wb)]), 64'hC0);
    check("sw w0 value", wlog_val[2'(wb)], 64'hBEEF_0000_0000_0000);
    check("sw w1 addr", 64'(wlog_addr[2'(wb + 1)]), 64'd1);
    check("sw w1 mask", 64'(wlog_mask[2'(wb + 1)]), 64'h03);
    check("sw w1 value", wlog_val[2'(wb + 1)], 64'h0000_0000_0000_DEAD);
    do_req("lwu cross", 1'b0, 3'b110, 13'h0006, 64'd0, 3, 1'b0, 64'h0000_0000_DEAD_BEEF, 0, 2, wb, rb);

    do_req("sb top", 1'b1, 3'b000, 13'h1FFF, 64'h34, 2, 1'b0, 64'd0, 1, 0, wb, rb);
    check("sb top addr", 64'(wlog_addr[2'(wb)]), 64'd1023);
    check("sb top mask", 64'(wlog_mask[2'(wb)]), 64'h80);
    do_req("sb zero", 1'b1, 3'b000, 13'h0000, 64'h92, 2, 1'b0, 64'd0, 1, 0, wb, rb);
    check("sb zero mask", 64'(wlog_mask[2'(wb)]), 64'h01);
    do_req("lh wrap", 1'b0, 3'b001, 13'h1FFF, 64'd0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_9234, 0, 2, wb, rb);
    check("lh wrap rd0", 64'(rlog_addr[2'(rb)]), 64'd1023);
    check("lh wrap rd1", 64'(rlog_addr[2'(rb + 1)]), 64'd0);

    do_req("load f3=111", 1'b0, 3'b111, 13'h0010, 64'd0, 1, 1'b1, 64'd0, 0, 0, wb, rb);
    do_req("store f3=100", 1'b1, 3'b100, 13'h0010, 64'hFFFF, 1, 1'b1, 64'd0, 0, 0, wb, rb);

    // Reset during the second half of a crossing store
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr            = 1'b0;
    req_valid      = 1'b1;
    req_write      = 1'b1;
    req_funct3     = 3'b010;
    req_address    = 13'h03FE;
    req_store_data = 64'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst-abort acc0 write", 64'(ram_write), 64'd1);
    check("rst-abort acc0 addr", 64'(ram_address), 64'h7F);
    check("rst-abort acc0 mask", 64'(ram_mask), 64'hC0);
    @(negedge clk);
    check("rst-abort acc1 addr", 64'(ram_address), 64'h80);
    check("rst-abort acc1 mask", 64'(ram_mask), 64'h03);
    rst_n = 1'b0;
    #1;
    check("rst-abort strobe dropped", 64'(ram_write), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst-abort ready", 64'(req_ready), 64'd1);
    check("rst-abort no resp", 64'(resp_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst-abort quiet", 64'({resp_valid, ram_write, ram_read}), 64'd0);
    end
    check("rst-abort w0 kept", mem[10'h7F], 64'hF00D_0000_0000_0000);
    check("rst-abort w1 untouched", mem[10'h80], 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
